// File: rtl/crc_serial_pkg.sv
// Shared types, default constants and the single-bit CRC step used by the
// serial CRC accumulator and its LFSR core.
package crc_serial_pkg;

    typedef enum logic [1:0] {IDLE, ACC, DONE} crc_state_t;

    localparam int         CRC_MAXW      = 32;
    localparam int         CRC_DEF_WIDTH = 8;
    localparam logic [7:0] CRC_DEF_POLY  = 8'h07;
    localparam logic [7:0] CRC_DEF_INIT  = 8'h00;

    // One MSB-first LFSR step on a right-aligned register of 'width' bits.
    function automatic logic [CRC_MAXW-1:0] crc_step(
        input logic [CRC_MAXW-1:0] crc,
        input logic                d,
        input logic [CRC_MAXW-1:0] poly,
        input int                  width
    );
        logic [CRC_MAXW-1:0] msb_sh;
        logic [CRC_MAXW-1:0] mask;
        logic                fb;
        msb_sh = crc >> (width - 1);
        fb     = msb_sh[0] ^ d;
        mask   = (width >= CRC_MAXW) ? {CRC_MAXW{1'b1}}
                                     : ((CRC_MAXW'(1) << width) - CRC_MAXW'(1));
        return ((crc << 1) ^ (fb ? poly : '0)) & mask;
    endfunction

endpackage

// File: rtl/crc_serial_lfsr.sv
// CRC register with seed-load and step-enable; nxt exposes the combinational
// next value so a caller can capture the final CRC in the same cycle.
module crc_serial_lfsr
    import crc_serial_pkg::*;
#(
    parameter int               WIDTH = CRC_DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = CRC_DEF_POLY,
    parameter logic [WIDTH-1:0] INIT  = CRC_DEF_INIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             d,
    output logic [WIDTH-1:0] crc,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0]    base;
    logic [CRC_MAXW-1:0] stepped;
    logic                unused_hi;

    // load restarts from the seed, so the first bit of a frame steps INIT
    assign base      = load ? INIT : crc;
    assign stepped   = crc_step(CRC_MAXW'(base), d, CRC_MAXW'(POLY), WIDTH);
    assign nxt       = stepped[WIDTH-1:0];
    assign unused_hi = ^(stepped >> WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= INIT;
        else if (en)
            crc <= nxt;
    end

endmodule

// File: rtl/crc_serial_acc.sv
// Bit-serial CRC accumulator with frame control and a one-cycle done strobe.
// Optional frame checking (EXP/ERR/ERRCNT) under `CRC_SERIAL_ACC_CHECK_EN.
module crc_serial_acc
    import crc_serial_pkg::*;
#(
    parameter int               WIDTH = CRC_DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = CRC_DEF_POLY,
    parameter logic [WIDTH-1:0] INIT  = CRC_DEF_INIT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             D,
    input  logic             DV,
    input  logic             SOF,
    input  logic             EOF,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             BUSY
`ifdef CRC_SERIAL_ACC_CHECK_EN
    ,
    input  logic [WIDTH-1:0] EXP,
    output logic             ERR,
    output logic [7:0]       ERRCNT
`endif
);

    crc_state_t       state;
    crc_state_t       state_nxt;
    logic             start;
    logic             adv;
    logic             fin;
    logic [WIDTH-1:0] crc_nxt;
    logic [WIDTH-1:0] crc_reg_unused;

    crc_serial_lfsr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .clk  (CLK),
        .rst  (RST),
        .en   (start | adv),
        .load (start),
        .d    (D),
        .crc  (crc_reg_unused),
        .nxt  (crc_nxt)
    );

    // SOF is honoured in every state; it restarts any frame in progress
    always_comb begin
        start     = DV & SOF;
        adv       = DV & ~SOF & (state == ACC);
        fin       = DV & EOF & (SOF | (state == ACC));
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     state_nxt = ACC;
            DONE:    state_nxt = start ? ACC : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (fin)
            state_nxt = DONE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            Q     <= '0;
            QV    <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            QV    <= fin;
            BUSY  <= (state_nxt == ACC);
            if (fin)
                Q <= crc_nxt;
        end
    end

`ifdef CRC_SERIAL_ACC_CHECK_EN
    logic mismatch;
    assign mismatch = (crc_nxt != EXP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR    <= 1'b0;
            ERRCNT <= '0;
        end else if (fin) begin
            ERR <= mismatch;
            if (mismatch && (ERRCNT != 8'hFF))
                ERRCNT <= ERRCNT + 8'd1;
        end
    end
`endif

endmodule

// File: doc/crc_serial_acc.md
Name: crc_serial_acc

Overview:
- Bit-serial CRC accumulator, the sequential stage directly downstream of the 2-input XOR cells.
- Each accepted bit performs one LFSR step: feedback XOR plus polynomial-tap XORs.
- Used for scan/BIST signature and frame-check generation in mcu7t5v0 test logic.
- Emits the final CRC word with a one-cycle done strobe at end of frame.

Parameters:
- WIDTH, 8, CRC register width (2..32)
- POLY, 8'h07, generator polynomial taps, implicit x^WIDTH term omitted
- INIT, 8'h00, register seed loaded at start of frame

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  reset, asynchronous, active-high
- D  input  1  serial data bit, MSB first
- DV  input  1  D valid this cycle; low = stall, no state change
- SOF  input  1  first bit of frame (qualified by DV)
- EOF  input  1  last bit of frame (qualified by DV)
- Q  output  WIDTH  final CRC of last completed frame
- QV  output  1  one-cycle pulse, Q updated
- BUSY  output  1  frame in progress (state ACC)

Behaviour:
- Interface: one clock, CLK; reset is asynchronous and active-high, on RST.
- Reset: state=IDLE, crc=INIT, Q=0, QV=0, BUSY=0. RST asserted mid-frame aborts the frame immediately; no QV is produced for it.
- Step function: fb = crc[WIDTH-1] ^ D; crc_next = {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0).
- States are IDLE, ACC, DONE.
- IDLE:
  - DV&SOF: crc <= step(INIT,D) and go to ACC.
  - DV&SOF&EOF: single-bit frame; Q <= step(INIT,D), QV <= 1, go to DONE.
  - DV without SOF is ignored.
- ACC:
  - DV&!SOF: crc <= step(crc,D).
  - DV&EOF: additionally Q <= step(crc,D), QV <= 1, go to DONE.
  - DV&SOF: restart; crc <= step(INIT,D), abandoned frame is dropped, no QV. SOF&EOF here is treated as a single-bit frame (as in IDLE).
  - DV low: hold everything.
- DONE: lasts exactly one cycle; QV=1 during it.
  - DV&SOF is accepted, same as IDLE, giving back-to-back frames with zero gap.
  - Otherwise go to IDLE.
  - Non-SOF bits in DONE are ignored.
- Latency: Q/QV are valid the cycle after the EOF bit is sampled.
- Q holds its value until the next frame completes.
- BUSY = (state==ACC), registered.
- No internal limit on frame length; crc wraps naturally.

Optional Feature:
- Macro: CRC_SERIAL_ACC_CHECK_EN.
- When defined:
  - Adds input EXP[WIDTH-1:0], sampled with the EOF bit.
  - Adds output ERR (1): registered with QV, =1 when the final CRC != EXP.
  - Adds output ERRCNT[7:0]: saturating count of mismatched frames; reset to 0; saturates at 255.
- When undefined: the ports and logic are absent, and base behaviour is identical.

Decomposition:
- Shared package crc_serial_pkg holds:
  - state enum {IDLE, ACC, DONE}
  - default WIDTH/POLY/INIT constants
  - pure function crc_step(crc,d,poly)
- One natural sub-module, crc_serial_lfsr: the combinational step plus crc register with load/enable, reusable by a future parallel-CRC checker.

Test Plan:
- Reset mid-frame: RST pulses after 3 bits of 0x31; QV never fires, BUSY=0, and the next frame computes correctly.
- Byte 0x31 (MSB first, DV continuous, SOF on bit7, EOF on bit0), POLY=07, INIT=00 -> QV one cycle after EOF, Q=8'h97.
- Byte 0x01 with DV deasserted for 3 random cycles mid-frame -> Q=8'h07, QV exactly once, BUSY high from bit1 through EOF.
- Back-to-back frames: 0x31, then SOF on the DONE cycle with 0x00 -> Q=8'h97 then Q=8'h00, two QV pulses, no dropped bit.
- SOF reasserted after 4 bits of 0xFF, then full 0x31 -> single QV, Q=8'h97. Separately, SOF&EOF with D=1 from IDLE -> Q=8'h07 next cycle.
- With CRC_SERIAL_ACC_CHECK_EN: frame 0x31 with EXP=8'h97 -> ERR=0; EXP=8'h96 -> ERR=1, ERRCNT=1; 300 bad frames -> ERRCNT=255.
